// File: rtl/instr_dcd_pkg.sv
// Shared definitions for the burst-capable SPI instruction decoder.
package instr_dcd_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_FETCH,
        S_DATA,
        S_WR,
        S_DONE
    } state_t;

    localparam int HDR_RW     = 7;
    localparam int HDR_BURST  = 6;
    localparam int HDR_ADDR_W = 6;

endpackage

// File: rtl/byte_word_pack.sv
// Register word holder: parallel load for reads, MSB-first byte shift-in for writes,
// and a byte selector (index 0 = most significant byte) feeding the SPI output byte.
module byte_word_pack #(
    parameter int DATA_BYTES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic [8*DATA_BYTES-1:0]   i_load_word,
    input  logic                      i_shift,
    input  logic [7:0]                i_byte,
    input  logic [1:0]                i_sel,
    output logic [8*DATA_BYTES-1:0]   o_word,
    output logic [7:0]                o_sel_byte
);

    localparam int DW = 8 * DATA_BYTES;

    logic [DW-1:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else if (i_load) begin
            r_word <= i_load_word;
        end else if (i_shift) begin
            r_word <= DW'({r_word, i_byte});
        end
    end

    always_comb begin
        o_sel_byte = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (i_sel == 2'(DATA_BYTES - 1 - b)) begin
                o_sel_byte = r_word[8*b +: 8];
            end
        end
    end

    assign o_word = r_word;

endmodule

// File: rtl/instr_dcd_burst.sv
// SPI byte stream to register read/write strobes, 1..4 byte words, auto-increment bursts.
// States: S_HDR header wait | S_FETCH read strobe | S_DATA word bytes | S_WR write strobe | S_DONE wait for cs_n.
module instr_dcd_burst
    import instr_dcd_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_BYTES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cs_n,
    input  logic                      byte_sync,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    output logic                      read,
    output logic                      write,
    output logic [ADDR_W-1:0]         addr,
    input  logic [8*DATA_BYTES-1:0]   data_read,
    output logic [8*DATA_BYTES-1:0]   data_write,
    output logic                      overrun
);

    localparam int         DW   = 8 * DATA_BYTES;
    localparam logic [1:0] LAST = 2'(DATA_BYTES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_cnt;
    logic [1:0]          w_cnt_nxt;
    logic                r_rw;
    logic                r_burst;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_data_out;
    logic                r_overrun;

    logic                w_byte;
    logic                w_hdr_load;
    logic                w_addr_inc;
    logic                w_load;
    logic                w_shift;
    logic                w_dout_next;
    logic                w_ovr;
    logic [7:0]          w_sel_byte;
    logic [DW-1:0]       w_word;

    assign w_byte = byte_sync & ~cs_n;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hdr_load  = 1'b0;
        w_addr_inc  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_dout_next = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_byte) begin
                    w_hdr_load  = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = data_in[HDR_RW] ? S_DATA : S_FETCH;
                end
            end
            S_FETCH: begin
                w_load      = 1'b1;
                w_ovr       = w_byte;
                w_cnt_nxt   = 2'd0;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_byte) begin
                    w_shift = r_rw;
                    if (r_cnt == LAST) begin
                        w_cnt_nxt = 2'd0;
                        if (r_rw) begin
                            w_state_nxt = S_WR;
                        end else if (r_burst) begin
                            w_addr_inc  = 1'b1;
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_dout_next = ~r_rw;
                        w_cnt_nxt   = r_cnt + 2'd1;
                    end
                end
            end
            S_WR: begin
                w_ovr = w_byte;
                if (r_burst) begin
                    w_addr_inc  = 1'b1;
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_HDR;
                w_cnt_nxt   = 2'd0;
            end
        endcase
        // Deselect aborts the frame; a strobe already in flight this cycle still goes out.
        if (cs_n) begin
            w_state_nxt = S_HDR;
            w_cnt_nxt   = 2'd0;
            w_addr_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HDR;
            r_cnt      <= 2'd0;
            r_rw       <= 1'b0;
            r_burst    <= 1'b0;
            r_addr     <= '0;
            r_data_out <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_overrun <= w_ovr;
            if (w_hdr_load) begin
                r_rw    <= data_in[HDR_RW];
                r_burst <= data_in[HDR_BURST];
                r_addr  <= data_in[ADDR_W-1:0];
            end else if (w_addr_inc) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_load) begin
                r_data_out <= data_read[DW-1 -: 8];
            end else if (w_dout_next) begin
                r_data_out <= w_sel_byte;
            end
        end
    end

    byte_word_pack #(
        .DATA_BYTES (DATA_BYTES)
    ) u_pack (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_word (data_read),
        .i_shift     (w_shift),
        .i_byte      (data_in),
        .i_sel       (r_cnt + 2'd1),
        .o_word      (w_word),
        .o_sel_byte  (w_sel_byte)
    );

    assign data_out   = r_data_out;
    assign read       = (r_state == S_FETCH);
    assign write      = (r_state == S_WR);
    assign addr       = r_addr;
    assign data_write = w_word;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_instr_dcd_burst.sv
// Directed self-checking bench for instr_dcd_burst with 16-bit words and 6-bit addresses.
module tb_instr_dcd_burst;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        byte_sync = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        read;
    logic        write;
    logic [5:0]  addr;
    logic [15:0] data_read;
    logic [15:0] data_write;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (addr)
            6'd1:    data_read = 16'h1357;
            6'd2:    data_read = 16'h2468;
            6'd3:    data_read = 16'hBEEF;
            default: data_read = 16'h0F0F;
        endcase
    end

    instr_dcd_burst #(.ADDR_W(6), .DATA_BYTES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write),
        .overrun    (overrun)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the edge that captured the byte (cycle t+1).
    task automatic send_byte(input logic [7:0] b);
        byte_sync = 1'b1;
        data_in   = b;
        step();
        byte_sync = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(3);
        n_cmp++; if (data_out !== 8'h00)    begin n_err++; $display("FAIL rst_data_out got %h exp 00", data_out); end
        n_cmp++; if (read !== 1'b0)         begin n_err++; $display("FAIL rst_read got %b exp 0", read); end
        n_cmp++; if (write !== 1'b0)        begin n_err++; $display("FAIL rst_write got %b exp 0", write); end
        n_cmp++; if (addr !== 6'd0)         begin n_err++; $display("FAIL rst_addr got %h exp 00", addr); end
        n_cmp++; if (data_write !== 16'h0)  begin n_err++; $display("FAIL rst_data_write got %h exp 0000", data_write); end
        n_cmp++; if (overrun !== 1'b0)      begin n_err++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_single;
        cs_n = 1'b0;
        step();
        send_byte(8'h85);
        n_cmp++; if (addr !== 6'd5)  begin n_err++; $display("FAIL wr_hdr_addr got %h exp 05", addr); end
        n_cmp++; if (read !== 1'b0)  begin n_err++; $display("FAIL wr_hdr_noread got %b exp 0", read); end
        step(2);
        send_byte(8'h12);
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL wr_early got %b exp 0", write); end
        step(2);
        send_byte(8'h34);
        n_cmp++; if (write !== 1'b1)          begin n_err++; $display("FAIL wr_strobe got %b exp 1", write); end
        n_cmp++; if (addr !== 6'd5)           begin n_err++; $display("FAIL wr_addr got %h exp 05", addr); end
        n_cmp++; if (data_write !== 16'h1234) begin n_err++; $display("FAIL wr_data got %h exp 1234", data_write); end
        step();
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL wr_single got %b exp 0", write); end
        send_byte(8'h56);
        step(2);
        send_byte(8'h78);
        step();
        n_cmp++; if (write !== 1'b0)          begin n_err++; $display("FAIL wr_done_ignore got %b exp 0", write); end
        n_cmp++; if (data_write !== 16'h1234) begin n_err++; $display("FAIL wr_done_data got %h exp 1234", data_write); end
        cs_n = 1'b1;
        step(2);
    endtask

    task automatic test_read_single;
        cs_n = 1'b0;
        step();
        send_byte(8'h03);
        n_cmp++; if (read !== 1'b1)  begin n_err++; $display("FAIL rd_strobe got %b exp 1", read); end
        n_cmp++; if (addr !== 6'd3)  begin n_err++; $display("FAIL rd_addr got %h exp 03", addr); end
        n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL rd_nowrite got %b exp 0", write); end
        step();
        n_cmp++; if (read !== 1'b0)      begin n_err++; $display("FAIL rd_single got %b exp 0", read); end
        n_cmp++; if (data_out !== 8'hBE) begin n_err++; $display("FAIL rd_msb got %h exp BE", data_out); end
        step();
        send_byte(8'h00);
        n_cmp++; if (data_out !== 8'hEF) begin n_err++; $display("FAIL rd_lsb got %h exp EF", data_out); end
        cs_n = 1'b1;
        step(2);
    endtask

    task automatic test_burst_write;
        logic [15:0] words [3];
        logic [5:0]  exp_addr [3];
        words[0] = 16'h1111; words[1] = 16'hA55A; words[2] = 16'h3C3C;
        exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0;
        cs_n = 1'b0;
        step();
        send_byte(8'hFE);
        step(2);
        for (int w = 0; w < 3; w++) begin
            send_byte(words[w][15:8]);
            step(2);
            send_byte(words[w][7:0]);
            n_cmp++; if (write !== 1'b1)         begin n_err++; $display("FAIL bw_strobe[%0d] got %b exp 1", w, write); end
            n_cmp++; if (addr !== exp_addr[w])   begin n_err++; $display("FAIL bw_addr[%0d] got %h exp %h", w, addr, exp_addr[w]); end
            n_cmp++; if (data_write !== words[w]) begin n_err++; $display("FAIL bw_data[%0d] got %h exp %h", w, data_write, words[w]); end
            step();
            n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL bw_single[%0d] got %b exp 0", w, write); end
            step();
        end
        n_cmp++; if (addr !== 6'd1) begin n_err++; $display("FAIL bw_final_addr got %h exp 01", addr); end
        cs_n = 1'b1;
        step(2);
    endtask

    task automatic test_burst_read;
        cs_n = 1'b0;
        step();
        send_byte(8'h41);
        n_cmp++; if (read !== 1'b1) begin n_err++; $display("FAIL br_strobe0 got %b exp 1", read); end
        n_cmp++; if (addr !== 6'd1) begin n_err++; $display("FAIL br_addr0 got %h exp 01", addr); end
        step();
        n_cmp++; if (data_out !== 8'h13) begin n_err++; $display("FAIL br_w0_msb got %h exp 13", data_out); end
        step();
        send_byte(8'h00);
        n_cmp++; if (data_out !== 8'h57) begin n_err++; $display("FAIL br_w0_lsb got %h exp 57", data_out); end
        step(2);
        send_byte(8'h00);
        n_cmp++; if (read !== 1'b1) begin n_err++; $display("FAIL br_strobe1 got %b exp 1", read); end
        n_cmp++; if (addr !== 6'd2) begin n_err++; $display("FAIL br_addr1 got %h exp 02", addr); end
        step();
        n_cmp++; if (read !== 1'b0)      begin n_err++; $display("FAIL br_single1 got %b exp 0", read); end
        n_cmp++; if (data_out !== 8'h24) begin n_err++; $display("FAIL br_w1_msb got %h exp 24", data_out); end
        step();
        send_byte(8'h00);
        n_cmp++; if (data_out !== 8'h68) begin n_err++; $display("FAIL br_w1_lsb got %h exp 68", data_out); end
        cs_n = 1'b1;
        step(2);
    endtask

    task automatic test_cs_abort;
        cs_n = 1'b0;
        step();
        send_byte(8'h84);
        step(2);
        send_byte(8'hAA);
        cs_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (write !== 1'b0) begin n_err++; $display("FAIL abort_nowrite[%0d] got %b exp 0", i, write); end
        end
        send_byte(8'h82);
        n_cmp++; if (addr !== 6'd4) begin n_err++; $display("FAIL abort_cs_high_ignored got %h exp 04", addr); end
        cs_n = 1'b0;
        step();
        send_byte(8'h03);
        n_cmp++; if (read !== 1'b1) begin n_err++; $display("FAIL abort_next_read got %b exp 1", read); end
        n_cmp++; if (addr !== 6'd3) begin n_err++; $display("FAIL abort_next_addr got %h exp 03", addr); end
        step();
        n_cmp++; if (data_out !== 8'hBE) begin n_err++; $display("FAIL abort_next_msb got %h exp BE", data_out); end
        cs_n = 1'b1;
        step(2);
    endtask

    task automatic test_overrun_reset;
        cs_n = 1'b0;
        step();
        send_byte(8'h87);
        step(2);
        send_byte(8'h9A);
        step(2);
        send_byte(8'hBC);
        n_cmp++; if (write !== 1'b1)          begin n_err++; $display("FAIL ov_strobe got %b exp 1", write); end
        n_cmp++; if (data_write !== 16'h9ABC) begin n_err++; $display("FAIL ov_data got %h exp 9ABC", data_write); end
        send_byte(8'h55);
        n_cmp++; if (overrun !== 1'b1)        begin n_err++; $display("FAIL ov_pulse got %b exp 1", overrun); end
        n_cmp++; if (write !== 1'b0)          begin n_err++; $display("FAIL ov_write_once got %b exp 0", write); end
        n_cmp++; if (data_write !== 16'h9ABC) begin n_err++; $display("FAIL ov_dropped got %h exp 9ABC", data_write); end
        n_cmp++; if (addr !== 6'd7)           begin n_err++; $display("FAIL ov_addr got %h exp 07", addr); end
        step();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ov_one_cycle got %b exp 0", overrun); end
        cs_n = 1'b1;
        step(2);
        cs_n = 1'b0;
        step();
        send_byte(8'h03);
        step(2);
        rst = 1'b1;
        step();
        n_cmp++; if (data_out !== 8'h00)   begin n_err++; $display("FAIL mid_rst_data_out got %h exp 00", data_out); end
        n_cmp++; if (read !== 1'b0)        begin n_err++; $display("FAIL mid_rst_read got %b exp 0", read); end
        n_cmp++; if (write !== 1'b0)       begin n_err++; $display("FAIL mid_rst_write got %b exp 0", write); end
        n_cmp++; if (addr !== 6'd0)        begin n_err++; $display("FAIL mid_rst_addr got %h exp 00", addr); end
        n_cmp++; if (data_write !== 16'h0) begin n_err++; $display("FAIL mid_rst_data_write got %h exp 0000", data_write); end
        n_cmp++; if (overrun !== 1'b0)     begin n_err++; $display("FAIL mid_rst_overrun got %b exp 0", overrun); end
        rst = 1'b0;
        step();
        send_byte(8'h82);
        n_cmp++; if (addr !== 6'd2) begin n_err++; $display("FAIL post_rst_hdr_addr got %h exp 02", addr); end
        n_cmp++; if (read !== 1'b0) begin n_err++; $display("FAIL post_rst_hdr_rw got %b exp 0", read); end
        cs_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_read_single();
        test_burst_write();
        test_burst_read();
        test_cs_abort();
        test_overrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
